// File: rtl/intbasic_pkg.sv
// Shared definitions for the integer arithmetic blocks: FSM state encoding
// and a constant clog2 used to size step counters.
package intbasic_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_INITS = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/product_plus_remainder_18_4.sv
// Sequential shift-add multiply-accumulate: result = multiplicand * multiplier + addend.
// Rebuilds a dividend from quotient, divisor and remainder using the divider handshake.
module product_plus_remainder_18_4
  import intbasic_pkg::*;
#(
  parameter int W  = 18,
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      multiplicand,
  input  logic [DW-1:0]     multiplier,
  input  logic [W-1:0]      addend,
  output logic [W+DW-1:0]   result,
  output logic              result_ready
);

  localparam int RW = W + DW;
  localparam int CW = clog2(DW + 1);

  state_t          state, state_nx;
  logic [RW-1:0]   acc, acc_nx;
  logic [RW-1:0]   mc, mc_nx;
  logic [DW-1:0]   mp, mp_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [RW-1:0]   result_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_READY;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mc     <= mc_nx;
      mp     <= mp_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
    end
  end

  // start wins over RUN progress so a mid-operation request restarts cleanly
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mc_nx     = mc;
    mp_nx     = mp;
    cnt_nx    = cnt;
    result_nx = result;
    if (start) begin
      state_nx = ST_INITS;
    end else begin
      case (state)
        ST_INITS: begin
          acc_nx   = {{DW{1'b0}}, addend};
          mc_nx    = {{DW{1'b0}}, multiplicand};
          mp_nx    = multiplier;
          cnt_nx   = CW'(DW);
          state_nx = ST_RUN;
        end
        ST_RUN: begin
          // exit as soon as the remaining multiplier bits are all zero
          if (cnt == '0 || mp == '0) begin
            result_nx = acc;
            state_nx  = ST_READY;
          end else begin
            acc_nx = acc + (mp[0] ? mc : '0);
            mc_nx  = mc << 1;
            mp_nx  = mp >> 1;
            cnt_nx = cnt - CW'(1);
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  assign result_ready = (state == ST_READY) & ~start;

endmodule
